// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 32-to-1 channel mux: steps the select over enabled channels,
// settles, samples, and publishes a registered snapshot with change mask. Optional IRQ: SCAN_IRQ_EN.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        cont_i,
    input  logic [31:0] ch_mask_i,
    input  logic        mux_o_i,
`ifdef SCAN_IRQ_EN
    input  logic        irq_clr_i,
    output logic        irq_o,
`endif
    output logic [4:0]  sel_o,
    output logic        busy_o,
    output logic [31:0] snapshot_o,
    output logic [31:0] changed_o,
    output logic        valid_o
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  settle_q, settle_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] snap_d, chg_d;
    logic        valid_d;
    logic        adv;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        snap_d   = snapshot_o;
        chg_d    = changed_o;
        valid_d  = 1'b0;
        adv      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stop_i && start_i && (ch_mask_i != '0)) begin
                    state_d  = SCAN;
                    mask_d   = ch_mask_i;
                    idx_d    = '0;
                    settle_d = '0;
                    shadow_d = snapshot_o;
                end
            end
            SCAN: begin
                if (stop_i) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    settle_d = '0;
                end else begin
                    if (!mask_q[idx_q]) begin
                        adv = 1'b1;
                    end else if (settle_q == SETTLE_C) begin
                        shadow_d[idx_q] = mux_o_i;
                        settle_d        = '0;
                        adv             = 1'b1;
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                    // idx wraps 31 -> 0 on the same edge that enters DONE
                    if (adv) begin
                        idx_d = idx_q + 5'd1;
                        if (idx_q == 5'd31) state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                idx_d    = '0;
                settle_d = '0;
                if (!stop_i) begin
                    snap_d  = shadow_q;
                    chg_d   = (shadow_q ^ snapshot_o) & mask_q;
                    valid_d = 1'b1;
                    if (cont_i && (ch_mask_i != '0)) begin
                        state_d = SCAN;
                        mask_d  = ch_mask_i;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                idx_d    = '0;
                settle_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            settle_q   <= '0;
            shadow_q   <= '0;
            mask_q     <= '0;
            sel_o      <= '0;
            busy_o     <= 1'b0;
            snapshot_o <= '0;
            changed_o  <= '0;
            valid_o    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            shadow_q   <= shadow_d;
            mask_q     <= mask_d;
            sel_o      <= idx_d;
            busy_o     <= (state_d != IDLE);
            snapshot_o <= snap_d;
            changed_o  <= chg_d;
            valid_o    <= valid_d;
        end
    end

`ifdef SCAN_IRQ_EN
    // a set from this DONE outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_o <= 1'b0;
        end else if (valid_d && (chg_d != '0)) begin
            irq_o <= 1'b1;
        end else if (irq_clr_i) begin
            irq_o <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer that drives the 5-bit select of the 32-to-1 channel mux and collects all 32 channels into a parallel snapshot.
- Walks the select across enabled channels, waits a programmable settle time on each, then samples the mux output.
- Publishes the snapshot with a one-cycle valid strobe and a per-channel change mask.
- Sits between the mux and downstream logic that needs a registered 32-bit view of the inputs.

Parameters:
SETTLE, 2, cycles the select is held before sampling (legal 0..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  begin a scan (level-sampled in IDLE only)
stop_i  input  1  abort scan, return to IDLE
cont_i  input  1  continuous mode: rescan after each DONE
ch_mask_i  input  32  1 = channel scanned, 0 = skipped
mux_o_i  input  1  output of the 32-to-1 mux
sel_o  output  5  mux select, registered
busy_o  output  1  high in SCAN and DONE
snapshot_o  output  32  last completed scan result
changed_o  output  32  bits that differed from the previous snapshot (masked)
valid_o  output  1  one-cycle strobe: snapshot_o/changed_o updated

Behaviour:
- Reset (async, rst_n=0): state IDLE, sel_o=0, busy_o=0, valid_o=0, snapshot_o=0, changed_o=0; idx, settle counter, shadow and mask latch cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start_i=1 and ch_mask_i!=0 → SCAN next edge; latch ch_mask_i, idx=0, sel_o=0, shadow<=snapshot_o.
  - start_i with ch_mask_i==0 is ignored; no busy, no valid.
- SCAN, current channel idx with latched mask bit 0: one cycle, idx++, no sample, shadow[idx] keeps its previous value.
- SCAN, current channel idx with latched mask bit 1:
  - sel_o=idx for SETTLE cycles, counted by the settle counter.
  - Then one sample cycle: shadow[idx]<=mux_o_i at the end of that cycle; idx++ and sel_o=idx+1 at the same edge.
  - Per enabled channel: SETTLE+1 cycles. With SETTLE=0, sampling occurs at the end of the cycle in which sel_o first shows idx.
- Leaving idx=31 (processed or skipped) → DONE; idx and sel_o wrap to 0.
- DONE, one cycle:
  - snapshot_o<=shadow.
  - changed_o<=(shadow ^ snapshot_o) & mask_latch.
  - valid_o=1 in the cycle following DONE, coincident with the new snapshot_o.
  - Next state: cont_i=1 → SCAN with idx=0, re-latching ch_mask_i; if the new mask is 0, go to IDLE instead. cont_i=0 → IDLE.
- Latency: all 32 enabled → 32*(SETTLE+1) SCAN cycles, then 1 DONE cycle; valid_o 32*(SETTLE+1)+2 cycles after the edge that sampled start_i.
- Changing ch_mask_i mid-scan has no effect until the next scan start.
- start_i while busy: ignored.
- stop_i in SCAN or DONE: IDLE next edge (stop_i has priority over DONE's update). snapshot_o/changed_o unchanged, no valid_o, sel_o=0, busy_o=0. stop_i in IDLE has priority over start_i.
- busy_o is registered from the state: high exactly while state is SCAN or DONE.
- Asynchronous reset mid-scan: immediate reset values; the partial shadow is discarded.

Optional Feature:
SCAN_IRQ_EN
- Defined: adds ports irq_o (output, 1) and irq_clr_i (input, 1).
  - irq_o is a sticky flag set on any DONE whose changed result is nonzero.
  - irq_clr_i=1 clears it next edge; a set in the same cycle wins over the clear.
  - Reset 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
1. SETTLE=2, mask=FFFFFFFF, channels=A5A5_3C3C, pulse start → sel_o steps 0..31, each held 3 cycles; valid_o 98 cycles after start edge; snapshot_o=A5A5_3C3C, changed_o=A5A5_3C3C.
2. Mask=0000_00F0, channels=FFFFFFFF from snapshot 0 → only bits 7:4 sampled; snapshot_o=0000_00F0; scan length 28+4*3=40 SCAN cycles.
3. cont_i=1, flip channel 9 between scans → second valid_o has changed_o=0000_0200; third has changed_o=0; busy_o stays high throughout.
4. stop_i at SCAN idx=12 → IDLE next edge, sel_o=0, busy_o=0, no valid_o, snapshot_o unchanged.
5. Edge cases: start with mask=0 → no busy. start during scan → ignored. Assert rst_n=0 mid-scan → all outputs 0 immediately.
6. SCAN_IRQ_EN: change detected → irq_o=1 and stays set across scans; irq_clr_i pulse → 0; clear coincident with new change → remains 1.
